// File: rtl/id_pkg.sv
// Shared types for the instruction-decode stage.
// Holds the opcode/funct3/funct7 encodings, the 5-bit ALU operation code,
// the immediate-format selector, the skid-buffer occupancy states and the
// decoded control payload carried through the buffer.
// Optional feature macro used by importers: RV_M_EXT_EN (M-extension decode).
package id_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_alu_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_br_e;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_m_e;

  typedef enum logic [6:0] {
    F7_BASE   = 7'b0000000,
    F7_MULDIV = 7'b0000001,
    F7_ALT    = 7'b0100000
  } funct7_e;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB,
    ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Everything except the width-parametrised immediate and PC.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    alu_op_e    alu_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       we;
    logic       is_muldiv;
    logic       illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate generator.
// Ports: inst (32-bit instruction), fmt (immediate format select),
//        imm (XLEN-bit sign-extended immediate; 0 for IMM_NONE).
module id_imm_gen
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  // Size casts of signed values sign-extend to XLEN.
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = XLEN'($signed(inst[31:20]));
      IMM_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_U:   imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode stage: combinational RV32I decode of inst_i feeding a
// 2-entry skid buffer with valid/ready handshakes on both sides.
// Ports: clk, rst_n (async active-low), flush_i (drop buffered entries),
//        in_valid_i/in_ready_o + inst_i/pc_i (upstream),
//        out_valid_o/out_ready_i + decoded payload out_* (downstream).
// Macro RV_M_EXT_EN: when defined, R-type funct7=0000001 decodes MUL..REMU;
// otherwise that encoding is illegal and out_is_muldiv_o is constant 0.
//
// state     | meaning
// BUF_EMPTY | no buffered instruction, out_valid_o=0
// BUF_ONE   | entry 0 holds the head, entry 1 free
// BUF_TWO   | both entries full, in_ready_o=0
module id_decode_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [6:0]      out_opcode_o,
  output logic [2:0]      out_funct3_o,
  output logic [4:0]      out_alu_op_o,
  output logic [4:0]      out_rd_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [PC_W-1:0] out_pc_o,
  output logic            out_we_o,
  output logic            out_is_muldiv_o,
  output logic            out_illegal_o
);

  dec_ctrl_t       dec_ctrl;
  imm_fmt_e        imm_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            writes_rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;

  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    dec_ctrl        = '0;
    dec_ctrl.opcode = inst_i[6:0];
    dec_ctrl.funct3 = funct3;
    dec_ctrl.rd     = inst_i[11:7];
    dec_ctrl.rs1    = inst_i[19:15];
    dec_ctrl.rs2    = inst_i[24:20];
    dec_ctrl.alu_op = ALU_ADD;
    imm_fmt         = IMM_NONE;
    writes_rd       = 1'b0;
    case (inst_i[6:0])
      OPC_LOAD: begin
        imm_fmt   = IMM_I;
        writes_rd = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
          dec_ctrl.illegal = 1'b1;
      end
      OPC_STORE: begin
        imm_fmt = IMM_S;
        if (funct3 >= 3'b011) dec_ctrl.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        imm_fmt = IMM_B;
        case (funct3)
          F3_BEQ:  dec_ctrl.alu_op = ALU_EQ;
          F3_BNE:  dec_ctrl.alu_op = ALU_NE;
          F3_BLT:  dec_ctrl.alu_op = ALU_LT;
          F3_BGE:  dec_ctrl.alu_op = ALU_GE;
          F3_BLTU: dec_ctrl.alu_op = ALU_LTU;
          F3_BGEU: dec_ctrl.alu_op = ALU_GEU;
          default: dec_ctrl.illegal = 1'b1;
        endcase
      end
      OPC_JALR: begin
        imm_fmt   = IMM_I;
        writes_rd = 1'b1;
        if (funct3 != 3'b000) dec_ctrl.illegal = 1'b1;
      end
      OPC_JAL: begin
        imm_fmt   = IMM_J;
        writes_rd = 1'b1;
      end
      OPC_LUI: begin
        imm_fmt         = IMM_U;
        writes_rd       = 1'b1;
        dec_ctrl.alu_op = ALU_PASSB;
      end
      OPC_AUIPC: begin
        imm_fmt   = IMM_U;
        writes_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_fmt   = IMM_I;
        writes_rd = 1'b1;
        case (funct3)
          F3_ADD:  dec_ctrl.alu_op = ALU_ADD;
          F3_SLL: begin
            dec_ctrl.alu_op = ALU_SLL;
            if (funct7 != F7_BASE) dec_ctrl.illegal = 1'b1;
          end
          F3_SLT:  dec_ctrl.alu_op = ALU_SLT;
          F3_SLTU: dec_ctrl.alu_op = ALU_SLTU;
          F3_XOR:  dec_ctrl.alu_op = ALU_XOR;
          F3_SR: begin
            if (funct7 == F7_BASE)     dec_ctrl.alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_ctrl.alu_op = ALU_SRA;
            else                       dec_ctrl.illegal = 1'b1;
          end
          F3_OR:   dec_ctrl.alu_op = ALU_OR;
          default: dec_ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  dec_ctrl.alu_op = ALU_ADD;
            F3_SLL:  dec_ctrl.alu_op = ALU_SLL;
            F3_SLT:  dec_ctrl.alu_op = ALU_SLT;
            F3_SLTU: dec_ctrl.alu_op = ALU_SLTU;
            F3_XOR:  dec_ctrl.alu_op = ALU_XOR;
            F3_SR:   dec_ctrl.alu_op = ALU_SRL;
            F3_OR:   dec_ctrl.alu_op = ALU_OR;
            default: dec_ctrl.alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec_ctrl.alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          dec_ctrl.alu_op = ALU_SRA;
`ifdef RV_M_EXT_EN
        end else if (funct7 == F7_MULDIV) begin
          dec_ctrl.is_muldiv = 1'b1;
          case (funct3)
            F3_MUL:    dec_ctrl.alu_op = ALU_MUL;
            F3_MULH:   dec_ctrl.alu_op = ALU_MULH;
            F3_MULHSU: dec_ctrl.alu_op = ALU_MULHSU;
            F3_MULHU:  dec_ctrl.alu_op = ALU_MULHU;
            F3_DIV:    dec_ctrl.alu_op = ALU_DIV;
            F3_DIVU:   dec_ctrl.alu_op = ALU_DIVU;
            F3_REM:    dec_ctrl.alu_op = ALU_REM;
            default:   dec_ctrl.alu_op = ALU_REMU;
          endcase
`endif
        end else begin
          dec_ctrl.illegal = 1'b1;
        end
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
    // Illegal instructions still flow downstream but must have no side effects.
    dec_ctrl.we        = writes_rd && (inst_i[11:7] != 5'd0) && !dec_ctrl.illegal;
    dec_ctrl.is_muldiv = dec_ctrl.is_muldiv && !dec_ctrl.illegal;
  end

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst_i),
    .fmt  (imm_fmt),
    .imm  (dec_imm)
  );

  buf_state_e      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  dec_ctrl_t       ctrl_q [2];
  logic [XLEN-1:0] imm_q  [2];
  logic [PC_W-1:0] pc_q   [2];
  logic            accept, emit, load_head, load_tail, shift_tail;

  assign accept = in_valid_i && in_ready_q;
  assign emit   = (state_q != BUF_EMPTY) && out_ready_i;

  always_comb begin
    state_d    = state_q;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          state_d   = BUF_ONE;
          load_head = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && emit) begin
          load_head = 1'b1;
        end else if (accept) begin
          state_d   = BUF_TWO;
          load_tail = 1'b1;
        end else if (emit) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // in_ready_o is low here, so only a drain is possible.
        if (emit) begin
          state_d    = BUF_ONE;
          shift_tail = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (flush_i) state_d = BUF_EMPTY;
    in_ready_d = (state_d != BUF_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ctrl_q[i] <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      if (load_head) begin
        ctrl_q[0] <= dec_ctrl;
        imm_q[0]  <= dec_imm;
        pc_q[0]   <= pc_i;
      end else if (shift_tail) begin
        ctrl_q[0] <= ctrl_q[1];
        imm_q[0]  <= imm_q[1];
        pc_q[0]   <= pc_q[1];
      end
      if (load_tail) begin
        ctrl_q[1] <= dec_ctrl;
        imm_q[1]  <= dec_imm;
        pc_q[1]   <= pc_i;
      end
    end
  end

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = (state_q != BUF_EMPTY);
  assign out_opcode_o    = ctrl_q[0].opcode;
  assign out_funct3_o    = ctrl_q[0].funct3;
  assign out_alu_op_o    = ctrl_q[0].alu_op;
  assign out_rd_o        = ctrl_q[0].rd;
  assign out_rs1_o       = ctrl_q[0].rs1;
  assign out_rs2_o       = ctrl_q[0].rs2;
  assign out_imm_o       = imm_q[0];
  assign out_pc_o        = pc_q[0];
  assign out_we_o        = ctrl_q[0].we;
  assign out_is_muldiv_o = ctrl_q[0].is_muldiv;
  assign out_illegal_o   = ctrl_q[0].illegal;

endmodule
